// File: rtl/can_frame_tx.sv
// CAN 2.0B frame transmitter: serialises standard/extended data or remote
// frames onto the bit-timing layer with CRC-15, bit stuffing, arbitration,
// ACK checking and bounded automatic retransmission.
module can_frame_tx #(
  parameter int MAX_RETRY     = 3,
  parameter int BUS_IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_req,
  input  logic        bit_rx,
  output logic        bit_tx,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [28:0] tx_id,
  input  logic        tx_ide,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_len,
  input  logic [63:0] tx_data,
  output logic        tx_done,
  output logic        tx_acked,
  output logic        arb_lost,
  output logic        tx_err
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int IW = $clog2(BUS_IDLE_BITS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
  } state_t;

  state_t        state, state_nxt;
  logic [28:0]   req_id, req_id_nxt;
  logic          req_ide, req_ide_nxt;
  logic          req_rtr, req_rtr_nxt;
  logic [3:0]    req_len, req_len_nxt;
  logic [63:0]   req_data, req_data_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic [6:0]    idx, idx_nxt;
  logic [14:0]   crc, crc_nxt;
  logic [3:0]    crc_cnt, crc_cnt_nxt;
  logic          run_bit, run_bit_nxt;
  logic [2:0]    run_len, run_len_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          failed, failed_nxt;
  logic          bit_tx_nxt, tx_done_nxt, tx_acked_nxt, arb_lost_nxt, tx_err_nxt;

  logic [101:0]  frame_bits;
  logic [3:0]    n_bytes;
  logic [6:0]    arb_len, payload_len;
  logic          pay_bit, next_bit;
  logic [14:0]   crc_step;

  // Everything after SOF up to the last data bit, left aligned, MSB first.
  // Payload bits are indexed by idx rather than shifted out so a retry
  // simply restarts idx at zero.
  always_comb begin
    if (req_ide)
      frame_bits = {req_id[28:18], 1'b1, 1'b1, req_id[17:0], req_rtr,
                    1'b0, 1'b0, req_len, req_data};
    else
      frame_bits = {req_id[10:0], req_rtr, 1'b0, 1'b0, req_len, req_data, 20'b0};
    n_bytes     = req_rtr ? 4'd0 : ((req_len > 4'd8) ? 4'd8 : req_len);
    arb_len     = req_ide ? 7'd32 : 7'd12;
    payload_len = arb_len + 7'd6 + {n_bytes, 3'b000};
    pay_bit     = frame_bits[7'd101 - idx];
    crc_step    = {crc[13:0], 1'b0} ^ ((crc[14] ^ pay_bit) ? 15'h4599 : 15'h0000);
  end

  assign tx_ready = (state == S_IDLE);

  // Next-state and next-output decode; all frame progress gated by bit_req.
  always_comb begin
    state_nxt    = state;
    req_id_nxt   = req_id;
    req_ide_nxt  = req_ide;
    req_rtr_nxt  = req_rtr;
    req_len_nxt  = req_len;
    req_data_nxt = req_data;
    retry_nxt    = retry;
    idle_cnt_nxt = idle_cnt;
    idx_nxt      = idx;
    crc_nxt      = crc;
    crc_cnt_nxt  = crc_cnt;
    run_bit_nxt  = run_bit;
    run_len_nxt  = run_len;
    cnt_nxt      = cnt;
    failed_nxt   = failed;
    bit_tx_nxt   = bit_tx;
    tx_acked_nxt = tx_acked;
    tx_done_nxt  = 1'b0;
    arb_lost_nxt = 1'b0;
    tx_err_nxt   = 1'b0;
    next_bit     = 1'b1;
    case (state)
      S_IDLE: begin
        bit_tx_nxt = 1'b1;
        if (tx_valid) begin
          req_id_nxt   = tx_id;
          req_ide_nxt  = tx_ide;
          req_rtr_nxt  = tx_rtr;
          req_len_nxt  = tx_len;
          req_data_nxt = tx_data;
          retry_nxt    = '0;
          idle_cnt_nxt = '0;
          state_nxt    = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        bit_tx_nxt = 1'b1;
        if (bit_req) begin
          if (!bit_rx) begin
            idle_cnt_nxt = '0;
          end else if (idle_cnt == IW'(BUS_IDLE_BITS - 1)) begin
            // SOF is dominant; CRC of a single 0 from zero stays zero.
            bit_tx_nxt  = 1'b0;
            state_nxt   = S_SOF;
            idx_nxt     = '0;
            crc_nxt     = '0;
            crc_cnt_nxt = '0;
            run_bit_nxt = 1'b0;
            run_len_nxt = 3'd1;
            failed_nxt  = 1'b0;
          end else begin
            idle_cnt_nxt = idle_cnt + IW'(1);
          end
        end
      end
      S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC: begin
        if (bit_req) begin
          if (bit_rx != bit_tx) begin
            bit_tx_nxt = 1'b1;
            if (state == S_ARB && bit_tx) begin
              arb_lost_nxt = 1'b1;
              idle_cnt_nxt = '0;
              state_nxt    = S_WAIT_IDLE;
            end else begin
              tx_err_nxt = 1'b1;
              failed_nxt = 1'b1;
              cnt_nxt    = '0;
              state_nxt  = S_IFS;
            end
          end else if (run_len == 3'd5) begin
            // Stuff bit stays in the current field so arbitration still
            // covers stuff bits inside the arbitration field.
            bit_tx_nxt  = ~run_bit;
            run_bit_nxt = ~run_bit;
            run_len_nxt = 3'd1;
          end else begin
            if (idx != payload_len) begin
              next_bit = pay_bit;
              idx_nxt  = idx + 7'd1;
              crc_nxt  = crc_step;
              if (idx < arb_len)
                state_nxt = S_ARB;
              else if (idx < arb_len + 7'd6)
                state_nxt = S_CTRL;
              else
                state_nxt = S_DATA;
            end else if (crc_cnt != 4'd15) begin
              next_bit    = crc[14];
              crc_nxt     = {crc[13:0], 1'b0};
              crc_cnt_nxt = crc_cnt + 4'd1;
              state_nxt   = S_CRC;
            end else begin
              next_bit  = 1'b1;
              state_nxt = S_CRC_DEL;
            end
            bit_tx_nxt = next_bit;
            if (next_bit == run_bit) begin
              run_len_nxt = run_len + 3'd1;
            end else begin
              run_bit_nxt = next_bit;
              run_len_nxt = 3'd1;
            end
          end
        end
      end
      S_CRC_DEL, S_ACK_DEL: begin
        if (bit_req) begin
          bit_tx_nxt = 1'b1;
          cnt_nxt    = '0;
          if (bit_rx != bit_tx) begin
            tx_err_nxt = 1'b1;
            failed_nxt = 1'b1;
            state_nxt  = S_IFS;
          end else begin
            state_nxt = (state == S_CRC_DEL) ? S_ACK_SLOT : S_EOF;
          end
        end
      end
      S_ACK_SLOT: begin
        if (bit_req) begin
          bit_tx_nxt = 1'b1;
          state_nxt  = S_ACK_DEL;
          if (bit_rx) begin
            tx_err_nxt = 1'b1;
            failed_nxt = 1'b1;
          end
        end
      end
      S_EOF: begin
        if (bit_req) begin
          if (cnt == 3'd6) begin
            cnt_nxt   = '0;
            state_nxt = S_IFS;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      S_IFS: begin
        if (bit_req) begin
          if (cnt == 3'd2) begin
            if (failed && retry < RW'(MAX_RETRY)) begin
              retry_nxt    = retry + RW'(1);
              idle_cnt_nxt = '0;
              state_nxt    = S_WAIT_IDLE;
            end else begin
              tx_done_nxt  = 1'b1;
              tx_acked_nxt = ~failed;
              state_nxt    = S_IDLE;
            end
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      default: begin
        bit_tx_nxt = 1'b1;
        state_nxt  = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      req_id   <= '0;
      req_ide  <= 1'b0;
      req_rtr  <= 1'b0;
      req_len  <= '0;
      req_data <= '0;
      retry    <= '0;
      idle_cnt <= '0;
      idx      <= '0;
      crc      <= '0;
      crc_cnt  <= '0;
      run_bit  <= 1'b0;
      run_len  <= '0;
      cnt      <= '0;
      failed   <= 1'b0;
      bit_tx   <= 1'b1;
      tx_done  <= 1'b0;
      tx_acked <= 1'b0;
      arb_lost <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_id   <= req_id_nxt;
      req_ide  <= req_ide_nxt;
      req_rtr  <= req_rtr_nxt;
      req_len  <= req_len_nxt;
      req_data <= req_data_nxt;
      retry    <= retry_nxt;
      idle_cnt <= idle_cnt_nxt;
      idx      <= idx_nxt;
      crc      <= crc_nxt;
      crc_cnt  <= crc_cnt_nxt;
      run_bit  <= run_bit_nxt;
      run_len  <= run_len_nxt;
      cnt      <= cnt_nxt;
      failed   <= failed_nxt;
      bit_tx   <= bit_tx_nxt;
      tx_done  <= tx_done_nxt;
      tx_acked <= tx_acked_nxt;
      arb_lost <= arb_lost_nxt;
      tx_err   <= tx_err_nxt;
    end
  end

endmodule

// File: tb/tb_can_frame_tx.sv
// Self-checking bench for can_frame_tx: a frame-level model builds the
// expected stuffed bit stream; a per-cycle compare process checks all outputs.
module tb_can_frame_tx;
  localparam int MAX_RETRY     = 3;
  localparam int BUS_IDLE_BITS = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_req, bit_rx, bit_tx;
  logic        tx_valid, tx_ready;
  logic [28:0] tx_id;
  logic        tx_ide, tx_rtr;
  logic [3:0]  tx_len;
  logic [63:0] tx_data;
  logic        tx_done, tx_acked, arb_lost, tx_err;

  can_frame_tx #(.MAX_RETRY(MAX_RETRY), .BUS_IDLE_BITS(BUS_IDLE_BITS)) dut (
    .clk(clk), .rst(rst), .bit_req(bit_req), .bit_rx(bit_rx), .bit_tx(bit_tx),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id), .tx_ide(tx_ide),
    .tx_rtr(tx_rtr), .tx_len(tx_len), .tx_data(tx_data), .tx_done(tx_done),
    .tx_acked(tx_acked), .arb_lost(arb_lost), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic exp_tx = 1'b1, exp_ready = 1'b1, exp_done = 1'b0, exp_acked = 1'b0;
  logic exp_arb = 1'b0, exp_err = 1'b0;
  logic cmp_en = 1'b0;
  int gap = 2;
  int err_seen = 0, arb_seen = 0, done_seen = 0;

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare of every output against the model expectations.
  always @(negedge clk) begin
    if (cmp_en) begin
      check1("bit_tx",   64'(bit_tx),   64'(exp_tx));
      check1("tx_ready", 64'(tx_ready), 64'(exp_ready));
      check1("tx_done",  64'(tx_done),  64'(exp_done));
      check1("tx_acked", 64'(tx_acked), 64'(exp_acked));
      check1("arb_lost", 64'(arb_lost), 64'(exp_arb));
      check1("tx_err",   64'(tx_err),   64'(exp_err));
      if (tx_err)   err_seen++;
      if (arb_lost) arb_seen++;
      if (tx_done)  done_seen++;
    end
  end

  // Frame model: ub = unstuffed SOF..CRC, sb = stuffed stream SOF..IFS,
  // su = unstuffed index of each stuffed bit (-1 for stuff and tail bits).
  logic        ub[$];
  logic        sb[$];
  int          su[$];
  int          ack_pos, m_pre, m_maxrun;
  logic [14:0] m_crc;

  function automatic void build(input logic [28:0] id, input logic ide, input logic rtr,
                                input logic [3:0] len, input logic [63:0] data);
    int n, run;
    logic last;
    ub.delete(); sb.delete(); su.delete();
    n = rtr ? 0 : ((len > 4'd8) ? 8 : int'(len));
    ub.push_back(1'b0);
    if (!ide) begin
      for (int i = 10; i >= 0; i--) ub.push_back(id[i]);
      ub.push_back(rtr); ub.push_back(1'b0); ub.push_back(1'b0);
    end else begin
      for (int i = 28; i >= 18; i--) ub.push_back(id[i]);
      ub.push_back(1'b1); ub.push_back(1'b1);
      for (int i = 17; i >= 0; i--) ub.push_back(id[i]);
      ub.push_back(rtr); ub.push_back(1'b0); ub.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) ub.push_back(len[i]);
    for (int i = 0; i < 8 * n; i++) ub.push_back(data[63 - i]);
    m_crc = '0;
    foreach (ub[i]) m_crc = {m_crc[13:0], 1'b0} ^ ((m_crc[14] ^ ub[i]) ? 15'h4599 : 15'h0);
    for (int i = 14; i >= 0; i--) ub.push_back(m_crc[i]);
    run = 0; last = 1'b0; m_maxrun = 0;
    for (int i = 0; i < ub.size(); i++) begin
      if (run == 5) begin
        last = !last; sb.push_back(last); su.push_back(-1); run = 1;
      end
      if (run > 0 && ub[i] == last) run++;
      else begin run = 1; last = ub[i]; end
      sb.push_back(ub[i]); su.push_back(i);
      if (run > m_maxrun) m_maxrun = run;
    end
    if (run == 5) begin sb.push_back(!last); su.push_back(-1); end
    m_pre = sb.size();
    ack_pos = m_pre + 1;
    repeat (13) begin sb.push_back(1'b1); su.push_back(-1); end
  endfunction

  task automatic bit_cycle(input logic rx, input logic etx, input logic eerr,
                           input logic earb, input logic edone, input logic eacked);
    bit_req = 1'b1; bit_rx = rx;
    @(posedge clk); #1;
    exp_tx = etx; exp_err = eerr; exp_arb = earb; exp_done = edone;
    if (edone) begin exp_acked = eacked; exp_ready = 1'b1; end
    bit_req = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
      exp_err = 1'b0; exp_arb = 1'b0; exp_done = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      exp_err = 1'b0; exp_arb = 1'b0; exp_done = 1'b0;
    end
  endtask

  // Handshake, then leave tx_valid high with junk fields to show they are ignored.
  task automatic request(input logic [28:0] id, input logic ide, input logic rtr,
                         input logic [3:0] len, input logic [63:0] data);
    tx_id = id; tx_ide = ide; tx_rtr = rtr; tx_len = len; tx_data = data; tx_valid = 1'b1;
    @(posedge clk); #1;
    exp_ready = 1'b0;
    tx_id = ~id; tx_ide = ~ide; tx_rtr = ~rtr; tx_len = ~len; tx_data = ~data;
  endtask

  // One attempt: bus idle, then the model stream with the bus echoing the
  // driven bit. status 0 = completed, 1 = arbitration lost, 2 = stopped early.
  task automatic run_attempt(input bit ack, input int force_u, input int stop_u,
                             input bit end_done, input bit end_acked, output int status);
    status = 0;
    for (int i = 1; i <= BUS_IDLE_BITS; i++)
      bit_cycle(1'b1, (i == BUS_IDLE_BITS) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < sb.size(); k++) begin
      logic rx;
      rx = sb[k-1];
      if (k - 1 == ack_pos) rx = !ack;
      if (force_u >= 0 && su[k-1] == force_u) begin
        bit_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        status = 1;
        return;
      end
      bit_cycle(rx, sb[k], (k - 1 == ack_pos) && !ack, 1'b0, 1'b0, 1'b0);
      if (stop_u >= 0 && su[k] == stop_u) begin
        tx_valid = 1'b0;
        status = 2;
        return;
      end
    end
    tx_valid = 1'b0;
    bit_cycle(1'b1, 1'b1, 1'b0, 1'b0, end_done, end_acked);
  endtask

  initial begin
    int st, e0, a0, d0;
    logic [11:0] first12;
    rst = 1'b1; bit_req = 1'b0; bit_rx = 1'b1; tx_valid = 1'b0;
    tx_id = '0; tx_ide = 1'b0; tx_rtr = 1'b0; tx_len = '0; tx_data = '0;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    idle(3);

    // Standard frame, ID 0x123, DLC 2, data A5 5A, acknowledged.
    build(29'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000);
    check1("std_len", 64'(ub.size() + 13), 64'd63);
    d0 = done_seen;
    request(29'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000);
    run_attempt(1'b1, -1, -1, 1'b1, 1'b1, st);
    idle(3);
    check1("std_done_count", 64'(done_seen - d0), 64'd1);

    // Standard frame, all-zero ID, DLC 0: stuffing pattern and zero CRC.
    build(29'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    for (int i = 0; i < 12; i++) first12[11 - i] = sb[i];
    check1("zero_prefix", 64'(first12), 64'h041);
    check1("zero_crc", 64'(m_crc), 64'h0);
    check1("zero_stuffed_len", 64'(m_pre), 64'd40);
    check1("zero_maxrun_le5", 64'(m_maxrun <= 5), 64'd1);
    request(29'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    run_attempt(1'b1, -1, -1, 1'b1, 1'b1, st);
    idle(3);

    // Extended remote frame with DLC 8, back-to-back bit_req.
    build(29'h1ABCDEF0, 1'b1, 1'b1, 4'd8, 64'h1122_3344_5566_7788);
    check1("ext_len", 64'(ub.size() + 13), 64'd67);
    check1("ext_srr", 64'(ub[12]), 64'd1);
    check1("ext_ide", 64'(ub[13]), 64'd1);
    check1("ext_rtr", 64'(ub[32]), 64'd1);
    gap = 0;
    request(29'h1ABCDEF0, 1'b1, 1'b1, 4'd8, 64'h1122_3344_5566_7788);
    run_attempt(1'b1, -1, -1, 1'b1, 1'b1, st);
    idle(3);
    gap = 2;

    // Arbitration lost on ID bit 4 (unstuffed index 7), then clean resend.
    build(29'h135, 1'b0, 1'b0, 4'd1, 64'hC300_0000_0000_0000);
    e0 = err_seen; a0 = arb_seen; d0 = done_seen;
    request(29'h135, 1'b0, 1'b0, 4'd1, 64'hC300_0000_0000_0000);
    run_attempt(1'b1, 7, -1, 1'b0, 1'b0, st);
    for (int i = 0; i < 19; i++) bit_cycle(logic'(i % 2 == 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_attempt(1'b1, -1, -1, 1'b1, 1'b1, st);
    idle(3);
    check1("arb_pulses", 64'(arb_seen - a0), 64'd1);
    check1("arb_no_err", 64'(err_seen - e0), 64'd0);
    check1("arb_done", 64'(done_seen - d0), 64'd1);

    // No ACK: MAX_RETRY+1 frames, one tx_err per frame, single failed done.
    build(29'h2A5, 1'b0, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);
    e0 = err_seen; d0 = done_seen;
    request(29'h2A5, 1'b0, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);
    for (int a = 0; a <= MAX_RETRY; a++)
      run_attempt(1'b0, -1, -1, a == MAX_RETRY, 1'b0, st);
    idle(3);
    check1("nack_err_count", 64'(err_seen - e0), 64'd4);
    check1("nack_done_count", 64'(done_seen - d0), 64'd1);

    // Asynchronous reset in the middle of the data field.
    build(29'h123, 1'b0, 1'b0, 4'd4, 64'hDEAD_BEEF_0000_0000);
    d0 = done_seen;
    request(29'h123, 1'b0, 1'b0, 4'd4, 64'hDEAD_BEEF_0000_0000);
    run_attempt(1'b1, -1, 25, 1'b0, 1'b0, st);
    #3;
    rst = 1'b1;
    exp_tx = 1'b1; exp_ready = 1'b1; exp_done = 1'b0; exp_acked = 1'b0;
    exp_arb = 1'b0; exp_err = 1'b0;
    #1;
    check1("rst_bit_tx", 64'(bit_tx), 64'd1);
    check1("rst_tx_ready", 64'(tx_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    idle(5);
    check1("rst_no_done", 64'(done_seen - d0), 64'd0);
    request(29'h123, 1'b0, 1'b0, 4'd4, 64'hDEAD_BEEF_0000_0000);
    run_attempt(1'b1, -1, -1, 1'b1, 1'b1, st);
    idle(3);
    check1("post_rst_done", 64'(done_seen - d0), 64'd1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
